pe_array_scheduler: RTL and testbench

Layer-level sequencer for the convolution datapath. It walks the output feature map pixel by pixel. For each pixel it drives the start/stop routine handshake of the processing-element dataflow controller and steps the kernel tap index through K×K taps. It then hands the finished pixel to the writeback stage with a valid/ready handshake. It sits between the top-level layer control and the PE/PEDC pair.

---
 rtl/pas_pkg.sv | 35 +++
 rtl/pas_wrap_counter.sv | 44 ++++
 rtl/pe_array_scheduler.sv | 168 ++++++++++++++++
 tb/tb_pe_array_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pas_pkg.sv
// Shared definitions for the PE array scheduler.
// Holds the FSM state encoding and the width helpers used to size the tap,
// row and column counters (every counter is at least one bit wide).
package pas_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StAccum  = 3'd2,
    StStop   = 3'd3,
    StSettle = 3'd4,
    StWb     = 3'd5,
    StDone   = 3'd6
  } pas_state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned tap_w(input int unsigned k);
    return cnt_w(k * k);
  endfunction

  function automatic int unsigned row_w(input int unsigned out_h);
    return cnt_w(out_h);
  endfunction

  function automatic int unsigned col_w(input int unsigned out_w);
    return cnt_w(out_w);
  endfunction

endpackage

// File: rtl/pas_wrap_counter.sv
// Modulo-MAX counter with synchronous clear and increment enable.
// Ports:
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   clr_i         : synchronous clear to zero (wins over inc_i)
//   inc_i         : advance by one, wrapping from MAX-1 to 0
//   count_o       : current count
//   wrap_o        : high when count_o == MAX-1 and inc_i (combinational)
module pas_wrap_counter #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] Last = W'(MAX - 1);

  logic [W-1:0] count_q, count_d;

  assign wrap_o  = inc_i && (count_q == Last);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = wrap_o ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pe_array_scheduler.sv
// Layer-level sequencer for the convolution datapath.
// Walks the output feature map pixel by pixel: for each pixel it pulses the
// PEDC start routine, steps the kernel tap through K*K taps, pulses the stop
// routine, waits one settle cycle and offers the pixel to writeback.
// Ports:
//   PAS_Clk, PAS_Reset_InLow : clock and asynchronous active-low reset
//   PAS_Go                   : layer start, only looked at in idle
//   PAS_Abort                : abandon the current layer
//   PAS_Wb_Ready             : writeback accepts the offered pixel
//   PAS_Start_Routine/Stop   : one-cycle pulses to the PEDC
//   PAS_Tap_Index            : current kernel tap
//   PAS_Out_Row/Col          : current output pixel
//   PAS_Wb_Valid             : pixel offered to writeback
//   PAS_Busy, PAS_Done       : layer in progress / layer completed pulse
// All outputs come straight from flops.
module pe_array_scheduler
  import pas_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned OUT_W       = 26,
  parameter int unsigned OUT_H       = 26
) (
  input  logic                                   PAS_Clk,
  input  logic                                   PAS_Reset_InLow,
  input  logic                                   PAS_Go,
  input  logic                                   PAS_Abort,
  input  logic                                   PAS_Wb_Ready,
  output logic                                   PAS_Start_Routine,
  output logic                                   PAS_Stop_Routine,
  output logic [pas_pkg::tap_w(KERNEL_SIZE)-1:0] PAS_Tap_Index,
  output logic [pas_pkg::row_w(OUT_H)-1:0]       PAS_Out_Row,
  output logic [pas_pkg::col_w(OUT_W)-1:0]       PAS_Out_Col,
  output logic                                   PAS_Wb_Valid,
  output logic                                   PAS_Busy,
  output logic                                   PAS_Done
);

  localparam int unsigned Taps = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned TapW = tap_w(KERNEL_SIZE);
  localparam int unsigned RowW = row_w(OUT_H);
  localparam int unsigned ColW = col_w(OUT_W);

  pas_state_e state_q, state_d;
  logic       aborted_q, aborted_d;
  logic       start_q, stop_q, wb_valid_q, busy_q, done_q;

  logic tap_wrap, col_wrap, row_wrap;
  logic wb_hs, pix_clr;

  // Abort beats a simultaneous ready, so no handshake happens on abort.
  assign wb_hs   = (state_q == StWb) && PAS_Wb_Ready && !PAS_Abort;
  assign pix_clr = ((state_q == StIdle) && PAS_Go) || (state_q == StDone);

  // Tap is held at zero outside ACCUM, so every pixel starts from tap 0.
  pas_wrap_counter #(
    .MAX (Taps),
    .W   (TapW)
  ) u_tap_cnt (
    .clk_i   (PAS_Clk),
    .rst_ni  (PAS_Reset_InLow),
    .clr_i   (state_q != StAccum),
    .inc_i   (state_q == StAccum),
    .count_o (PAS_Tap_Index),
    .wrap_o  (tap_wrap)
  );

  pas_wrap_counter #(
    .MAX (OUT_W),
    .W   (ColW)
  ) u_col_cnt (
    .clk_i   (PAS_Clk),
    .rst_ni  (PAS_Reset_InLow),
    .clr_i   (pix_clr),
    .inc_i   (wb_hs),
    .count_o (PAS_Out_Col),
    .wrap_o  (col_wrap)
  );

  // Row wraps only when the last column of the last row is handed off.
  pas_wrap_counter #(
    .MAX (OUT_H),
    .W   (RowW)
  ) u_row_cnt (
    .clk_i   (PAS_Clk),
    .rst_ni  (PAS_Reset_InLow),
    .clr_i   (pix_clr),
    .inc_i   (col_wrap),
    .count_o (PAS_Out_Row),
    .wrap_o  (row_wrap)
  );

  always_comb begin
    state_d   = state_q;
    aborted_d = aborted_q;
    unique case (state_q)
      StIdle: begin
        if (PAS_Go) begin
          state_d   = StStart;
          aborted_d = 1'b0;
        end
      end
      StStart: begin
        // An opened routine is always closed through STOP, even on abort.
        if (PAS_Abort) begin
          state_d   = StStop;
          aborted_d = 1'b1;
        end else begin
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (PAS_Abort) begin
          state_d   = StStop;
          aborted_d = 1'b1;
        end else if (tap_wrap) begin
          state_d = StStop;
        end
      end
      StStop: begin
        state_d = PAS_Abort ? StIdle : StSettle;
      end
      StSettle: begin
        state_d = (PAS_Abort || aborted_q) ? StIdle : StWb;
      end
      StWb: begin
        if (PAS_Abort) begin
          state_d = StIdle;
        end else if (PAS_Wb_Ready) begin
          state_d = row_wrap ? StDone : StStart;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_ff @(posedge PAS_Clk or negedge PAS_Reset_InLow) begin
    if (!PAS_Reset_InLow) begin
      state_q    <= StIdle;
      aborted_q  <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      aborted_q  <= aborted_d;
      start_q    <= (state_d == StStart);
      stop_q     <= (state_d == StStop);
      wb_valid_q <= (state_d == StWb);
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StDone);
    end
  end

  assign PAS_Start_Routine = start_q;
  assign PAS_Stop_Routine  = stop_q;
  assign PAS_Wb_Valid      = wb_valid_q;
  assign PAS_Busy          = busy_q;
  assign PAS_Done          = done_q;

endmodule

// File: tb/tb_pe_array_scheduler.sv
// Directed bench for pe_array_scheduler: a K=3 2x2 instance and a K=1 2x2
// instance share clock, reset, abort and ready; each has its own Go.
module tb_pe_array_scheduler;

  logic clk = 1'b0;
  logic rst_n, go, go1, abort, ready;

  logic       st, sp, vld, busy, done;
  logic [3:0] tap;
  logic [0:0] row, col;
  logic       st1, sp1, vld1, busy1, done1;
  logic [0:0] tap1, row1, col1;

  int errors = 0;
  int checks = 0;

  // Per-cycle capture, index = cycle number after the Go edge.
  logic start_a[0:63], stop_a[0:63], done_a[0:63], valid_a[0:63], busy_a[0:63];
  int   tap_a[0:63], row_a[0:63], col_a[0:63];

  always #5 clk = ~clk;

  pe_array_scheduler #(
    .KERNEL_SIZE (3),
    .OUT_W       (2),
    .OUT_H       (2)
  ) dut (
    .PAS_Clk           (clk),
    .PAS_Reset_InLow   (rst_n),
    .PAS_Go            (go),
    .PAS_Abort         (abort),
    .PAS_Wb_Ready      (ready),
    .PAS_Start_Routine (st),
    .PAS_Stop_Routine  (sp),
    .PAS_Tap_Index     (tap),
    .PAS_Out_Row       (row),
    .PAS_Out_Col       (col),
    .PAS_Wb_Valid      (vld),
    .PAS_Busy          (busy),
    .PAS_Done          (done)
  );

  pe_array_scheduler #(
    .KERNEL_SIZE (1),
    .OUT_W       (2),
    .OUT_H       (2)
  ) dut_k1 (
    .PAS_Clk           (clk),
    .PAS_Reset_InLow   (rst_n),
    .PAS_Go            (go1),
    .PAS_Abort         (abort),
    .PAS_Wb_Ready      (ready),
    .PAS_Start_Routine (st1),
    .PAS_Stop_Routine  (sp1),
    .PAS_Tap_Index     (tap1),
    .PAS_Out_Row       (row1),
    .PAS_Out_Col       (col1),
    .PAS_Wb_Valid      (vld1),
    .PAS_Busy          (busy1),
    .PAS_Done          (done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse Go on the chosen instance, then record ncyc cycles. A second Go is
  // raised during cycle go_again (0 = none).
  task automatic capture(input int ncyc, input bit k1, input int go_again);
    if (k1) go1 = 1'b1; else go = 1'b1;
    tick();
    go  = 1'b0;
    go1 = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == go_again) begin
        if (k1) go1 = 1'b1; else go = 1'b1;
      end else begin
        go  = 1'b0;
        go1 = 1'b0;
      end
      start_a[c] = k1 ? st1   : st;
      stop_a[c]  = k1 ? sp1   : sp;
      done_a[c]  = k1 ? done1 : done;
      valid_a[c] = k1 ? vld1  : vld;
      busy_a[c]  = k1 ? busy1 : busy;
      tap_a[c]   = k1 ? int'(tap1) : int'(tap);
      row_a[c]   = k1 ? int'(row1) : int'(row);
      col_a[c]   = k1 ? int'(col1) : int'(col);
      tick();
    end
    go  = 1'b0;
    go1 = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200 && busy; i++) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({st, sp, tap, row, col, vld, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_state: outputs=%h required 0",
               {st, sp, tap, row, col, vld, busy, done});
    end
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (tap !== 4'd4) begin
      errors++;
      $display("FAIL reset_pre_tap: tap=%0d required 4", tap);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({st, sp, tap, row, col, vld, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_async: outputs=%h required 0",
               {st, sp, tap, row, col, vld, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({busy, st, tap} !== '0) begin
        errors++;
        $display("FAIL reset_idle: busy=%b start=%b tap=%0d required 0", busy, st, tap);
      end
    end
  endtask

  task automatic test_nominal();
    int ns, np, nd, both;
    capture(56, 1'b0, 0);
    ns = 0; np = 0; nd = 0; both = 0;
    for (int c = 1; c <= 56; c++) begin
      ns += int'(start_a[c]);
      np += int'(stop_a[c]);
      nd += int'(done_a[c]);
      both += int'(start_a[c] & stop_a[c]);
    end
    checks++;
    if (ns != 4 || np != 4 || both != 0) begin
      errors++;
      $display("FAIL nom_pulses: start=%0d stop=%0d overlap=%0d required 4 4 0", ns, np, both);
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (start_a[1 + 13 * p] !== 1'b1 || stop_a[11 + 13 * p] !== 1'b1) begin
        errors++;
        $display("FAIL nom_spacing p%0d: start=%b stop=%b required 1 1", p,
                 start_a[1 + 13 * p], stop_a[11 + 13 * p]);
      end
      for (int t = 0; t < 9; t++) begin
        checks++;
        if (tap_a[2 + 13 * p + t] != t) begin
          errors++;
          $display("FAIL nom_tap p%0d: tap=%0d required %0d", p, tap_a[2 + 13 * p + t], t);
        end
      end
      checks++;
      if (valid_a[13 + 13 * p] !== 1'b1 || row_a[13 + 13 * p] != p / 2 ||
          col_a[13 + 13 * p] != p % 2) begin
        errors++;
        $display("FAIL nom_pixel p%0d: valid=%b row=%0d col=%0d required 1 %0d %0d", p,
                 valid_a[13 + 13 * p], row_a[13 + 13 * p], col_a[13 + 13 * p], p / 2, p % 2);
      end
    end
    checks++;
    if (nd != 1 || done_a[53] !== 1'b1) begin
      errors++;
      $display("FAIL nom_done: count=%0d at53=%b required 1 1", nd, done_a[53]);
    end
    checks++;
    if (busy_a[53] !== 1'b1 || busy_a[54] !== 1'b0) begin
      errors++;
      $display("FAIL nom_busy: done_cycle=%b after=%b required 1 0", busy_a[53], busy_a[54]);
    end
  endtask

  task automatic test_backpressure();
    bit found;
    go = 1'b1;
    tick();
    go = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (vld && col == 1'b1) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL bp_reach: wb of pixel (0,1) not seen, required within 100 cycles");
    end else begin
      for (int i = 0; i < 6; i++) begin
        ready = (i == 5);
        checks++;
        if ({vld, row, col, st} !== 4'b1010) begin
          errors++;
          $display("FAIL bp_hold c%0d: vld,row,col,start=%b required 1010", i,
                   {vld, row, col, st});
        end
        tick();
      end
      ready = 1'b1;
      checks++;
      if ({st, row, col, vld} !== 4'b1100) begin
        errors++;
        $display("FAIL bp_release: start,row,col,vld=%b required 1100", {st, row, col, vld});
      end
    end
    wait_idle("bp");
  endtask

  task automatic test_abort_accum();
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (tap !== 4'd2) begin
      errors++;
      $display("FAIL abort_tap: tap=%0d required 2", tap);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({sp, st, busy} !== 3'b101) begin
      errors++;
      $display("FAIL abort_stop: stop,start,busy=%b required 101", {sp, st, busy});
    end
    tick();
    checks++;
    if ({busy, sp, st, vld} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_settle: busy,stop,start,vld=%b required 1000", {busy, sp, st, vld});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({busy, vld, done, st} !== 4'b0000) begin
        errors++;
        $display("FAIL abort_idle c%0d: busy,vld,done,start=%b required 0000", i,
                 {busy, vld, done, st});
      end
    end
  endtask

  task automatic test_abort_wb();
    bit found;
    go = 1'b1;
    tick();
    go = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (vld) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abwb_reach: wb not seen, required within 100 cycles");
    end
    abort = 1'b1;
    ready = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy, vld, done, row, col} !== 5'b00000) begin
        errors++;
        $display("FAIL abwb_idle c%0d: busy,vld,done,row,col=%b required 00000", i,
                 {busy, vld, done, row, col});
      end
      tick();
    end
  endtask

  task automatic test_go_busy_k1();
    int ns, nd;
    capture(56, 1'b0, 20);
    ns = 0; nd = 0;
    for (int c = 1; c <= 56; c++) begin
      ns += int'(start_a[c]);
      nd += int'(done_a[c]);
    end
    checks++;
    if (ns != 4 || start_a[40] !== 1'b1 || nd != 1 || done_a[53] !== 1'b1) begin
      errors++;
      $display("FAIL gobusy: starts=%0d s40=%b dones=%0d d53=%b required 4 1 1 1",
               ns, start_a[40], nd, done_a[53]);
    end
    capture(24, 1'b1, 0);
    ns = 0; nd = 0;
    for (int c = 1; c <= 24; c++) begin
      ns += int'(start_a[c]);
      nd += int'(done_a[c]);
      checks++;
      if (tap_a[c] != 0) begin
        errors++;
        $display("FAIL k1_tap c%0d: tap=%0d required 0", c, tap_a[c]);
      end
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (start_a[1 + 5 * p] !== 1'b1 || stop_a[3 + 5 * p] !== 1'b1 ||
          valid_a[5 + 5 * p] !== 1'b1) begin
        errors++;
        $display("FAIL k1_period p%0d: start=%b stop=%b valid=%b required 1 1 1", p,
                 start_a[1 + 5 * p], stop_a[3 + 5 * p], valid_a[5 + 5 * p]);
      end
    end
    checks++;
    if (ns != 4 || nd != 1 || done_a[21] !== 1'b1 || busy_a[22] !== 1'b0) begin
      errors++;
      $display("FAIL k1_done: starts=%0d dones=%0d d21=%b busy22=%b required 4 1 1 0",
               ns, nd, done_a[21], busy_a[22]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    go    = 1'b0;
    go1   = 1'b0;
    abort = 1'b0;
    ready = 1'b1;
    test_reset();
    test_nominal();
    test_backpressure();
    test_abort_accum();
    test_abort_wb();
    test_go_busy_k1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
